// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types and constants for the I/D cache arbiter.
package rv32i_types;

  localparam int LINE_W_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP_I,
    RESP_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/line_register.sv
// rtl/line_register.sv - load-enabled line-wide register with asynchronous reset.
module line_register #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line-fill/writeback port
// between the I-cache and D-cache.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state;
  arb_state_t        state_next;
  grant_t            last_grant;
  logic [31:0]       addr_q;
  logic              write_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] line_q;
  logic              grant_i;
  logic              grant_d;
  logic              serving;
  logic              line_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie the side that lost last time wins; otherwise whoever asks.
        if (i_read && (d_read || d_write)) begin
          grant_i = (last_grant == GRANT_D);
          grant_d = (last_grant == GRANT_I);
        end else begin
          grant_i = i_read;
          grant_d = d_read || d_write;
        end
        if (grant_i) begin
          state_next = SERVE_I;
        end else if (grant_d) begin
          state_next = SERVE_D;
        end
      end
      SERVE_I: if (pmem_resp) state_next = RESP_I;
      SERVE_D: if (pmem_resp) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request side is sampled only at grant so the memory sees stable values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_D;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else if (grant_i) begin
      last_grant <= GRANT_I;
      addr_q     <= i_address;
      write_q    <= 1'b0;
    end else if (grant_d) begin
      last_grant <= GRANT_D;
      addr_q     <= d_address;
      write_q    <= d_write;
      wdata_q    <= d_wdata;
    end
  end

  assign serving   = (state == SERVE_I) || (state == SERVE_D);
  assign line_load = serving && pmem_resp;

  line_register #(
    .W(LINE_W)
  ) u_line (
    .clk  (clk),
    .rst  (rst),
    .load (line_load),
    .d    (pmem_rdata),
    .q    (line_q)
  );

  assign pmem_read    = serving && !write_q;
  assign pmem_write   = serving && write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = (state == RESP_I);
  assign d_resp       = (state == RESP_D);
  assign i_rdata      = line_q;
  assign d_rdata      = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  int checks = 0;
  int errors = 0;
  int excl_bad = 0;

  int            rd_cyc, wr_cyc, n_iresp, n_dresp;
  logic [31:0]   addr_seen;
  logic [LW-1:0] wdata_seen;
  logic [LW-1:0] rdata_seen;
  logic          addr_stable;
  logic          idle_quiet;
  logic [LW-1:0] prev_line;
  int            quiet_bad;

  cache_arbiter #(.LINE_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pmem_read && pmem_write) excl_bad++;
    if (i_resp && d_resp) excl_bad++;
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller has placed a request in IDLE; memory answers on cycle lat of service.
  task automatic run_txn(input int lat, input logic [LW-1:0] data, input bit drop);
    rd_cyc = 0; wr_cyc = 0; n_iresp = 0; n_dresp = 0; addr_stable = 1'b1;
    @(negedge clk);
    addr_seen  = pmem_address;
    wdata_seen = pmem_wdata;
    if (drop) begin
      i_read = 0; d_read = 0; d_write = 0;
      i_address = 32'hdead_beef; d_address = 32'hdead_beef; d_wdata = '1;
    end
    for (int k = 1; k <= lat; k++) begin
      if (pmem_read) rd_cyc++;
      if (pmem_write) wr_cyc++;
      if (i_resp) n_iresp++;
      if (d_resp) n_dresp++;
      if (pmem_address !== addr_seen || pmem_wdata !== wdata_seen) addr_stable = 1'b0;
      if (k == lat) begin
        pmem_resp = 1'b1;
        pmem_rdata = data;
      end
      @(negedge clk);
    end
    pmem_resp = 1'b0;
    pmem_rdata = ~data;
    if (pmem_read) rd_cyc++;
    if (pmem_write) wr_cyc++;
    rdata_seen = 'x;
    if (i_resp) begin n_iresp++; rdata_seen = i_rdata; i_read = 0; end
    if (d_resp) begin n_dresp++; rdata_seen = d_rdata; d_read = 0; d_write = 0; end
    @(negedge clk);
    idle_quiet = !(pmem_read || pmem_write || i_resp || d_resp);
  endtask

  initial begin
    rst = 1; i_read = 0; i_address = 0; d_read = 0; d_write = 0; d_address = 0;
    d_wdata = 0; pmem_rdata = 0; pmem_resp = 0;
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // lone I-side fill
    i_read = 1; i_address = 32'h0000_0040;
    run_txn(5, {32{8'hA5}}, 0);
    check("i_fill_rd_cycles", rd_cyc, 5);
    check("i_fill_wr_cycles", wr_cyc, 0);
    check("i_fill_iresp", n_iresp, 1);
    check("i_fill_dresp", n_dresp, 0);
    check("i_fill_addr", addr_seen, 32'h0000_0040);
    check("i_fill_rdata", rdata_seen, {32{8'hA5}});
    check("i_fill_stable", addr_stable, 1);
    check("i_fill_idle_gap", idle_quiet, 1);
    check("i_fill_rdata_hold", i_rdata, {32{8'hA5}});

    // lone D-side writeback
    d_write = 1; d_address = 32'h0000_1000; d_wdata = {16{16'h1234}};
    run_txn(3, {32{8'h5A}}, 0);
    check("d_wb_wr_cycles", wr_cyc, 3);
    check("d_wb_rd_cycles", rd_cyc, 0);
    check("d_wb_dresp", n_dresp, 1);
    check("d_wb_iresp", n_iresp, 0);
    check("d_wb_addr", addr_seen, 32'h0000_1000);
    check("d_wb_wdata", wdata_seen, {16{16'h1234}});
    check("d_wb_idle_gap", idle_quiet, 1);

    // memory response while idle must be ignored
    prev_line = {32{8'h5A}};
    quiet_bad = 0;
    pmem_resp = 1; pmem_rdata = {32{8'hEE}};
    repeat (2) begin
      @(negedge clk);
      if (pmem_read || pmem_write || i_resp || d_resp) quiet_bad++;
    end
    pmem_resp = 0;
    check("spurious_quiet", quiet_bad, 0);
    check("spurious_i_rdata", i_rdata, prev_line);
    check("spurious_d_rdata", d_rdata, prev_line);

    // read and write together is a write
    d_read = 1; d_write = 1; d_address = 32'h0000_2000; d_wdata = {32{8'h77}};
    run_txn(2, {32{8'h11}}, 0);
    check("rw_wr_cycles", wr_cyc, 2);
    check("rw_rd_cycles", rd_cyc, 0);
    check("rw_dresp", n_dresp, 1);
    check("rw_wdata", wdata_seen, {32{8'h77}});

    // request withdrawn after grant still completes with latched values
    i_read = 1; i_address = 32'h0000_0080;
    run_txn(4, {32{8'hC3}}, 1);
    check("drop_rd_cycles", rd_cyc, 4);
    check("drop_iresp", n_iresp, 1);
    check("drop_addr", addr_seen, 32'h0000_0080);
    check("drop_stable", addr_stable, 1);
    check("drop_rdata", rdata_seen, {32{8'hC3}});

    // round-robin from a fresh reset: I, then D, then I, then D
    rst = 1;
    @(negedge clk);
    rst = 0;
    i_read = 1; i_address = 32'h0000_0100; d_read = 1; d_address = 32'h0000_0200;
    run_txn(2, {32{8'hB1}}, 0);
    check("tie1_addr", addr_seen, 32'h0000_0100);
    check("tie1_iresp", n_iresp, 1);
    check("tie1_dresp", n_dresp, 0);
    i_read = 1;
    run_txn(2, {32{8'hB2}}, 0);
    check("tie2_addr", addr_seen, 32'h0000_0200);
    check("tie2_dresp", n_dresp, 1);
    check("tie2_iresp", n_iresp, 0);
    check("tie2_d_rdata", rdata_seen, {32{8'hB2}});
    d_read = 1;
    run_txn(2, {32{8'hB3}}, 0);
    check("tie3_addr", addr_seen, 32'h0000_0100);
    check("tie3_iresp", n_iresp, 1);
    run_txn(1, {32{8'hB4}}, 0);
    check("tie4_addr", addr_seen, 32'h0000_0200);
    check("tie4_dresp", n_dresp, 1);

    // reset in the middle of a D-side fill
    d_read = 1; d_address = 32'h0000_0300;
    @(negedge clk);
    check("rstmid_serving", pmem_read, 1);
    #1 rst = 1;
    #1;
    check("rstmid_read_low", pmem_read, 0);
    check("rstmid_addr_clr", pmem_address, 0);
    @(negedge clk);
    rst = 0; d_read = 0;
    quiet_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (pmem_read || pmem_write || i_resp || d_resp) quiet_bad++;
    end
    check("rstmid_no_resp", quiet_bad, 0);
    check("rstmid_d_rdata", d_rdata, 0);

    check("exclusive_strobes_resps", excl_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
